mac_rx_fsm: RTL and testbench

MAC_RX_FSM -- requirements
Module: mac_rx_fsm

---
 rtl/mac_pkg.sv | 44 ++++
 rtl/crc32_d8.sv | 31 +++
 rtl/mac_rx_fsm.sv | 146 ++++++++++++++
 tb/tb_mac_rx_fsm.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module : mac_pkg
// Brief  : Shared frame-phase codes, preamble/SFD bytes and CRC-32 constants
//          for the MAC receive path and the learning stage.
// Rev    : 1.0 - initial release
// ============================================================================
package mac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_PREAMBLE = 3'b001,
        ST_SFD      = 3'b010,
        ST_DST_MAC  = 3'b011,
        ST_SRC_MAC  = 3'b100,
        ST_LEN_TYPE = 3'b101,
        ST_PAYLOAD  = 3'b110,
        ST_END      = 3'b111
    } mac_state_t;

    localparam logic [7:0]  c_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  c_SFD_BYTE      = 8'hD5;
    localparam logic [31:0] c_CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] c_CRC_RESIDUE   = 32'hC704DD7B;

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // LSB-first update, so the register holds the bit-reversed CRC.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ bitrev32(c_CRC_POLY);
            else             c = c >> 1;
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc32_d8.sv
`default_nettype none
// ============================================================================
// Module : crc32_d8
// Brief  : Byte-wide reflected CRC-32 accumulator with synchronous clear.
//          Only present when MAC_RX_FCS_CHECK_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`ifdef MAC_RX_FCS_CHECK_EN
module crc32_d8
    import mac_pkg::*;
(
    input  logic        iclk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [7:0]  i_d,
    output logic [31:0] o_crc
);

    logic [31:0] r_crc;

    always_ff @(posedge iclk) begin
        if (i_rst || i_clr) r_crc <= 32'hFFFF_FFFF;
        else if (i_en)      r_crc <= crc32_byte(r_crc, i_d);
    end

    assign o_crc = r_crc;

endmodule
`endif
`default_nettype wire

// File: rtl/mac_rx_fsm.sv
`default_nettype none
// ============================================================================
// Module : mac_rx_fsm
// Brief  : Receive frame-phase tracker: preamble/SFD detection, header/payload
//          phase codes, length, runt/oversize and (MAC_RX_FCS_CHECK_EN) FCS.
// Rev    : 1.0 - initial release
// ============================================================================
module mac_rx_fsm
    import mac_pkg::*;
#(
    parameter int pDATA_WIDTH        = 8,
    parameter int pMAX_PACKET_LENGHT = 1536,
    parameter int pMIN_PACKET_LENGHT = 64,
    parameter int pPREAMBLE_MIN      = 6
)(
    input  logic                   iclk,
    input  logic                   i_rst,
    input  logic                   i_dv,
    input  logic [pDATA_WIDTH-1:0] irx_d,
    output logic [2:0]             o_fsm_state,
    output logic [pDATA_WIDTH-1:0] o_rx_d,
    output logic                   o_dv,
    output logic [10:0]            o_frame_len,
    output logic                   o_frame_ok,
    output logic [2:0]             o_err
);

    localparam logic [10:0] c_MAX_LEN = 11'(pMAX_PACKET_LENGHT);
    localparam logic [10:0] c_MIN_LEN = 11'(pMIN_PACKET_LENGHT);
    localparam logic [2:0]  c_PRE_MIN = 3'(pPREAMBLE_MIN);

    mac_state_t             r_state, w_next;
    logic                   r_dv_prev;
    logic [2:0]             r_pre_cnt, w_pre_cnt;
    logic [10:0]            r_cnt;
    logic [pDATA_WIDTH-1:0] r_rx_d;
    logic                   r_dv;
    logic [2:0]             r_err;
    logic                   r_ok;
    logic                   w_cnt_clr, w_cnt_inc, w_oversize, w_fcs_err;
    logic [2:0]             w_err;
    logic [7:0]             w_byte;

    assign w_byte = irx_d[7:0];

    always_comb begin
        w_next     = r_state;
        w_pre_cnt  = r_pre_cnt;
        w_cnt_clr  = 1'b0;
        w_cnt_inc  = 1'b0;
        w_oversize = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_dv && !r_dv_prev && w_byte == c_PREAMBLE_BYTE) begin
                    w_next    = ST_PREAMBLE;
                    w_pre_cnt = 3'd1;
                end
            end
            ST_PREAMBLE: begin
                if (!i_dv) begin
                    w_next = ST_IDLE;
                end else if (w_byte == c_PREAMBLE_BYTE) begin
                    if (r_pre_cnt != 3'd7) w_pre_cnt = r_pre_cnt + 3'd1;
                end else if (w_byte == c_SFD_BYTE && r_pre_cnt >= c_PRE_MIN) begin
                    w_next    = ST_SFD;
                    w_cnt_clr = 1'b1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_SFD, ST_DST_MAC, ST_SRC_MAC, ST_LEN_TYPE, ST_PAYLOAD: begin
                if (!i_dv) begin
                    w_next = ST_END;
                end else if (r_cnt == c_MAX_LEN) begin
                    w_next     = ST_END;
                    w_oversize = 1'b1;
                end else begin
                    // r_cnt is the index of the byte now on irx_d
                    w_cnt_inc = 1'b1;
                    if (r_cnt < 11'd6)       w_next = ST_DST_MAC;
                    else if (r_cnt < 11'd12) w_next = ST_SRC_MAC;
                    else if (r_cnt < 11'd14) w_next = ST_LEN_TYPE;
                    else                     w_next = ST_PAYLOAD;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

`ifdef MAC_RX_FCS_CHECK_EN
    logic [31:0] w_crc;

    crc32_d8 u_crc32_d8 (
        .iclk  (iclk),
        .i_rst (i_rst),
        .i_clr (w_cnt_clr),
        .i_en  (w_cnt_inc),
        .i_d   (w_byte),
        .o_crc (w_crc)
    );

    assign w_fcs_err = (w_crc != bitrev32(c_CRC_RESIDUE));
`else
    assign w_fcs_err = 1'b0;
`endif

    assign w_err = {w_fcs_err, w_oversize, (r_cnt < c_MIN_LEN)};

    always_ff @(posedge iclk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_pre_cnt <= 3'd0;
            r_cnt     <= 11'd0;
            r_rx_d    <= '0;
            r_dv      <= 1'b0;
            r_err     <= 3'b000;
            r_ok      <= 1'b0;
            // Treat the line as busy so a frame already in flight is not decoded.
            r_dv_prev <= 1'b1;
        end else begin
            r_state   <= w_next;
            r_pre_cnt <= w_pre_cnt;
            r_rx_d    <= irx_d;
            r_dv      <= i_dv;
            r_dv_prev <= i_dv;
            if (w_cnt_clr)      r_cnt <= 11'd0;
            else if (w_cnt_inc) r_cnt <= r_cnt + 11'd1;
            if (w_next == ST_END) begin
                r_err <= w_err;
                r_ok  <= (w_err == 3'b000);
            end else begin
                r_err <= 3'b000;
                r_ok  <= 1'b0;
            end
        end
    end

    assign o_fsm_state = r_state;
    assign o_rx_d      = r_rx_d;
    assign o_dv        = r_dv;
    assign o_frame_len = r_cnt;
    assign o_err       = r_err;
    assign o_frame_ok  = r_ok;

endmodule
`default_nettype wire

// File: tb/tb_mac_rx_fsm.sv
`default_nettype none
// ============================================================================
// Module : tb_mac_rx_fsm
// Brief  : Scoreboard bench for mac_rx_fsm; expectations derived per frame.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_mac_rx_fsm;

    localparam int c_MAX     = 1536;
    localparam int c_MIN     = 64;
    localparam int c_PRE_MIN = 6;
`ifdef MAC_RX_FCS_CHECK_EN
    localparam bit c_FCS_EN = 1'b1;
`else
    localparam bit c_FCS_EN = 1'b0;
`endif

    localparam logic [2:0] S_IDLE = 3'b000, S_PRE = 3'b001, S_SFD = 3'b010,
                           S_DST  = 3'b011, S_SRC = 3'b100, S_LEN = 3'b101,
                           S_PAY  = 3'b110, S_END = 3'b111;

    typedef struct {
        logic [2:0]  st;
        logic [7:0]  rx;
        logic        dv;
        logic [10:0] len;
        logic [2:0]  err;
        logic        ok;
    } exp_t;

    logic        iclk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_dv = 1'b0;
    logic [7:0]  irx_d = 8'h00;
    logic [2:0]  o_fsm_state;
    logic [7:0]  o_rx_d;
    logic        o_dv;
    logic [10:0] o_frame_len;
    logic        o_frame_ok;
    logic [2:0]  o_err;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   g_len    = 0;

    mac_rx_fsm #(
        .pDATA_WIDTH        (8),
        .pMAX_PACKET_LENGHT (c_MAX),
        .pMIN_PACKET_LENGHT (c_MIN),
        .pPREAMBLE_MIN      (c_PRE_MIN)
    ) dut (
        .iclk        (iclk),
        .i_rst       (i_rst),
        .i_dv        (i_dv),
        .irx_d       (irx_d),
        .o_fsm_state (o_fsm_state),
        .o_rx_d      (o_rx_d),
        .o_dv        (o_dv),
        .o_frame_len (o_frame_len),
        .o_frame_ok  (o_frame_ok),
        .o_err       (o_err)
    );

    always #5 iclk = ~iclk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if ((c[0] ^ b[i]) == 1'b1) c = (c >> 1) ^ 32'hEDB88320;
            else                       c = c >> 1;
        end
        return c;
    endfunction

    function automatic logic [2:0] region(input int k);
        if (k < 6)       return S_DST;
        else if (k < 12) return S_SRC;
        else if (k < 14) return S_LEN;
        else             return S_PAY;
    endfunction

    // Apply one input cycle and queue what the outputs must show after the edge.
    task automatic drive(input bit rst, input bit dv, input logic [7:0] d,
                         input logic [2:0] st, input logic [2:0] err);
        exp_t e;
        i_rst = rst;
        i_dv  = dv;
        irx_d = d;
        e.st  = st;
        e.rx  = rst ? 8'h00 : d;
        e.dv  = rst ? 1'b0 : dv;
        e.len = 11'(g_len);
        e.err = err;
        e.ok  = (st == S_END) && (err == 3'b000);
        sb.push_back(e);
        @(negedge iclk);
    endtask

    task automatic send_frame(input int npre, input int nbytes, input bit corrupt, input int rst_at);
        logic [7:0]  data[$];
        logic [31:0] crc;
        logic [31:0] fcs;
        bit          in_frame;
        data = {};
        crc  = 32'hFFFF_FFFF;
        if (nbytes > c_MAX) begin
            for (int k = 0; k < nbytes; k++) begin
                if (k <= c_MAX)           data.push_back(8'($urandom));
                else if (k == c_MAX + 10) data.push_back(8'hD5);
                else                      data.push_back(8'h55);
            end
        end else begin
            for (int k = 0; k < nbytes - 4; k++) begin
                data.push_back(8'($urandom));
                if (rst_at >= 0 && k == rst_at + 1) data[k] = 8'h55;
                crc = crc_step(crc, data[k]);
            end
            fcs = ~crc;
            for (int k = 0; k < 4; k++) data.push_back(fcs[8*k +: 8]);
            if (corrupt) data[nbytes-4] = data[nbytes-4] ^ 8'h01;
        end

        for (int i = 0; i < npre; i++) drive(1'b0, 1'b1, 8'h55, S_PRE, 3'b000);
        in_frame = (npre >= c_PRE_MIN);
        if (in_frame) g_len = 0;
        drive(1'b0, 1'b1, 8'hD5, in_frame ? S_SFD : S_IDLE, 3'b000);

        for (int k = 0; k < nbytes; k++) begin
            if (k == rst_at) begin
                g_len = 0;
                drive(1'b1, 1'b1, data[k], S_IDLE, 3'b000);
                in_frame = 1'b0;
            end else if (!in_frame) begin
                drive(1'b0, 1'b1, data[k], S_IDLE, 3'b000);
            end else if (k < c_MAX) begin
                g_len = k + 1;
                drive(1'b0, 1'b1, data[k], region(k), 3'b000);
            end else begin
                drive(1'b0, 1'b1, data[k], S_END, {c_FCS_EN, 1'b1, 1'b0});
                in_frame = 1'b0;
            end
        end

        if (in_frame)
            drive(1'b0, 1'b0, 8'h00, S_END, {c_FCS_EN & corrupt, 1'b0, (g_len < c_MIN)});
        else
            drive(1'b0, 1'b0, 8'h00, S_IDLE, 3'b000);
        repeat (3) drive(1'b0, 1'b0, 8'h00, S_IDLE, 3'b000);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge iclk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_eq("fsm_state", 32'(o_fsm_state), 32'(e.st));
                check_eq("rx_d",      32'(o_rx_d),      32'(e.rx));
                check_eq("dv",        32'(o_dv),        32'(e.dv));
                check_eq("frame_len", 32'(o_frame_len), 32'(e.len));
                check_eq("err",       32'(o_err),       32'(e.err));
                check_eq("frame_ok",  32'(o_frame_ok),  32'(e.ok));
            end
        end
    end

    initial begin : stimulus
        g_len = 0;
        repeat (2) drive(1'b1, 1'b0, 8'h00, S_IDLE, 3'b000);
        repeat (3) drive(1'b0, 1'b0, 8'h00, S_IDLE, 3'b000);

        send_frame(7, 64, 1'b0, -1);     // nominal minimum-size good frame
        send_frame(5, 10, 1'b0, -1);     // short preamble: never leaves IDLE after D5
        send_frame(7, 40, 1'b0, -1);     // runt
        send_frame(7, 64, 1'b1, -1);     // flipped FCS bit
        send_frame(8, 100, 1'b0, -1);    // preamble count saturation
        send_frame(7, 1600, 1'b0, -1);   // oversize with 55/D5 in the ignored tail
        send_frame(6, 64, 1'b0, -1);     // minimum preamble, right after oversize
        send_frame(7, 64, 1'b0, 20);     // reset mid-frame at byte 20
        send_frame(7, 70, 1'b0, -1);     // recovery frame after reset

        repeat (2) @(negedge iclk);
        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
